// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- registered ALU between operand fetch and writeback.
//
// Takes one operation per in_valid/in_ready handshake and returns the result
// and Z/N/C/V flags through a one-entry output register drained by
// out_valid/out_ready. Single-cycle ops land in the output register on the
// accept edge. MUL, when built in, runs a shift-add loop over BIT_COUNT edges.
//
// Build option:
//   ALU_MUL_EN  defined   -> op 11 is an iterative multiplier (IDLE/MUL_BUSY FSM)
//               undefined -> op 11 is illegal (c=0, Z=1), no FSM registers
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready request handshake
//   a, b, op          operands and encoded operation
//   out_valid/out_ready result handshake
//   c, alu_flags      registered result and flags {V,C,N,Z}
//   o_dbg_state       current FSM state (0=IDLE, 1=MUL_BUSY)
//
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid && ready. A producer holding valid keeps its payload stable until
// that edge; c/alu_flags never change while out_valid && !out_ready.
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int BIT_COUNT = 8,
    parameter int OP_W      = 4,
    parameter int SHAMT_W   = $clog2(BIT_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_COUNT-1:0] a,
    input  logic [BIT_COUNT-1:0] b,
    input  logic [OP_W-1:0]      op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_COUNT-1:0] c,
    output logic [3:0]           alu_flags,
    output logic [0:0]           o_dbg_state
);

    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_NOT  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SHL  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SHR  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_ASR  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_BYPA = OP_W'(9);
    localparam logic [OP_W-1:0] OP_BYPB = OP_W'(10);

    localparam logic [0:0] ST_IDLE = 1'b0;

    localparam int MSB = BIT_COUNT - 1;

    // Width constants for comparing b and clamping the shift amount.
    localparam logic [BIT_COUNT-1:0] LP_BC    = BIT_COUNT'(BIT_COUNT);
    localparam logic [SHAMT_W:0]     LP_SH_BC = (SHAMT_W+1)'(BIT_COUNT);

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic [BIT_COUNT:0]   w_add;
    logic [BIT_COUNT:0]   w_sub;
    logic                 w_b_ge;
    logic                 w_b_gt;
    logic [SHAMT_W:0]     w_sh_n;
    logic [BIT_COUNT:0]   w_shl_ext;
    logic [BIT_COUNT:0]   w_shr_ext;
    logic [BIT_COUNT:0]   w_asr_ext;
    logic [BIT_COUNT-1:0] w_res;
    logic                 w_c_flag;
    logic                 w_v_flag;
    logic [3:0]           w_flags;
    logic                 w_accept;

    assign w_add = {1'b0, a} + {1'b0, b};
    // Bit BIT_COUNT of the widened difference is the borrow (a < b unsigned).
    assign w_sub = {1'b0, a} - {1'b0, b};

    // Shift amounts of BIT_COUNT and above are clamped to BIT_COUNT; the
    // widened vectors below then keep the last bit shifted out in their
    // extra bit, which is exactly the C flag.
    assign w_b_ge = (b >= LP_BC);
    assign w_b_gt = (b >  LP_BC);
    assign w_sh_n = w_b_ge ? LP_SH_BC : {1'b0, b[SHAMT_W-1:0]};

    assign w_shl_ext = {1'b0, a} << w_sh_n;            // [BIT_COUNT] = carry out
    assign w_shr_ext = {a, 1'b0} >> w_sh_n;            // [0] = carry out
    assign w_asr_ext = $unsigned($signed({a, 1'b0}) >>> w_sh_n);

    always_comb begin
        w_res    = '0;
        w_c_flag = 1'b0;
        w_v_flag = 1'b0;
        case (op)
            OP_ADD: begin
                w_res    = w_add[MSB:0];
                w_c_flag = w_add[BIT_COUNT];
                w_v_flag = (a[MSB] == b[MSB]) && (w_add[MSB] != a[MSB]);
            end
            OP_SUB: begin
                w_res    = w_sub[MSB:0];
                w_c_flag = w_sub[BIT_COUNT];
                w_v_flag = (a[MSB] != b[MSB]) && (w_sub[MSB] != a[MSB]);
            end
            OP_AND:  w_res = a & b;
            OP_OR:   w_res = a | b;
            OP_XOR:  w_res = a ^ b;
            OP_NOT:  w_res = ~a;
            OP_SHL: begin
                // Beyond BIT_COUNT nothing of a is the "last bit out".
                if (!w_b_gt) begin
                    w_res    = w_shl_ext[MSB:0];
                    w_c_flag = w_shl_ext[BIT_COUNT];
                end
            end
            OP_SHR: begin
                if (!w_b_gt) begin
                    w_res    = w_shr_ext[BIT_COUNT:1];
                    w_c_flag = w_shr_ext[0];
                end
            end
            OP_ASR: begin
                w_res    = w_asr_ext[BIT_COUNT:1];
                w_c_flag = w_asr_ext[0];
            end
            OP_BYPA: w_res = a;
            OP_BYPB: w_res = b;
            default: begin
                // Illegal codes (and MUL, which never loads through here):
                // c=0 gives Z=1 with the other flags clear.
                w_res = '0;
            end
        endcase
    end

    assign w_flags  = {w_v_flag, w_c_flag, w_res[MSB], (w_res == '0)};
    assign w_accept = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Output-register load source
    // ------------------------------------------------------------------
    logic                 w_load;
    logic [BIT_COUNT-1:0] w_load_c;
    logic [3:0]           w_load_flags;

`ifdef ALU_MUL_EN
    localparam logic [OP_W-1:0]    OP_MUL      = OP_W'(11);
    localparam logic [0:0]         ST_MUL_BUSY = 1'b1;
    localparam logic [SHAMT_W-1:0] LP_CNT_LAST = SHAMT_W'(BIT_COUNT - 1);

    logic [0:0]             r_state;
    logic [2*BIT_COUNT-1:0] r_mcand;
    logic [BIT_COUNT-1:0]   r_mplier;
    logic [2*BIT_COUNT-1:0] r_acc;
    logic [SHAMT_W-1:0]     r_cnt;

    logic                   w_is_mul;
    logic                   w_mul_start;
    logic                   w_mul_done;
    logic [2*BIT_COUNT-1:0] w_acc_next;
    logic                   w_mul_hi_nz;

    assign w_is_mul    = (op == OP_MUL);
    assign w_mul_start = w_accept && w_is_mul;
    assign w_mul_done  = (r_state == ST_MUL_BUSY) && (r_cnt == LP_CNT_LAST);
    assign w_acc_next  = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_hi_nz = (w_acc_next[2*BIT_COUNT-1:BIT_COUNT] != '0);

    // A MUL is only accepted when the output register is empty or draining
    // on that same edge, so out_valid is naturally low for the whole loop.
    assign in_ready    = (r_state == ST_IDLE) && (!out_valid || out_ready);
    assign o_dbg_state = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (w_mul_start) begin
            r_state  <= ST_MUL_BUSY;
            r_mcand  <= {{BIT_COUNT{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == ST_MUL_BUSY) begin
            // One shift-add step: add the shifted multiplicand when the
            // current multiplier LSB is set.
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (w_mul_done) begin
                r_state <= ST_IDLE;
            end
        end
    end

    always_comb begin
        w_load       = 1'b0;
        w_load_c     = w_res;
        w_load_flags = w_flags;
        if (w_accept && !w_is_mul) begin
            w_load = 1'b1;
        end else if (w_mul_done) begin
            w_load       = 1'b1;
            w_load_c     = w_acc_next[MSB:0];
            w_load_flags = {w_mul_hi_nz, w_mul_hi_nz, w_acc_next[MSB],
                            (w_acc_next[MSB:0] == '0)};
        end
    end
`else
    assign in_ready     = !out_valid || out_ready;
    assign o_dbg_state  = ST_IDLE;
    assign w_load       = w_accept;
    assign w_load_c     = w_res;
    assign w_load_flags = w_flags;
`endif

    // ------------------------------------------------------------------
    // One-entry output register
    // ------------------------------------------------------------------
    logic                 r_out_valid;
    logic [BIT_COUNT-1:0] r_c;
    logic [3:0]           r_flags;

    // A load wins over a drain on the same edge, so out_valid stays high
    // when a new result replaces one being consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_c         <= '0;
            r_flags     <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_c         <= w_load_c;
            r_flags     <= w_load_flags;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign c         = r_c;
    assign alu_flags = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq -- directed-vector bench for alu_seq (BIT_COUNT=8).
// Expected {c, flags} values are hand-computed and queued when an operation
// is accepted; a monitor pops and compares on every drained result.
// Flags are written {V,C,N,Z}.
// -----------------------------------------------------------------------------
module tb_alu_seq;

    localparam int W  = 8;
    localparam int EW = W + 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   op = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] c;
    logic [3:0]   alu_flags;
    logic [0:0]   dbg_state;

    alu_seq #(.BIT_COUNT(W), .OP_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .op          (op),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .c           (c),
        .alu_flags   (alu_flags),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    string         exp_name_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every result leaving the block must match the queue head.
    logic [EW-1:0] mon_exp;
    int            mon_cyc;
    string         mon_name;
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output: got c=%h flags=%b expected no result", c, alu_flags);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_cyc  = exp_cyc_q.pop_front();
                mon_name = exp_name_q.pop_front();
                check(mon_name, {c, alu_flags}, mon_exp);
                if (mon_cyc >= 0) check_int({mon_name, "_latency"}, cyc, mon_cyc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // delay: edges from accept to result (0 = visible right after accept edge).
    task automatic issue(input string name, input logic [3:0] o,
                         input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [W-1:0] ec, input logic [3:0] ef,
                         input int delay, input bit chk_lat, input bit push);
        int waited;
        waited   = 0;
        op       = o;
        a        = ia;
        b        = ib;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_accept: got in_ready=0 for 50 cycles expected 1", name);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (push) begin
            exp_q.push_back({ec, ef});
            exp_cyc_q.push_back(chk_lat ? cyc + delay : -1);
            exp_name_q.push_back(name);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("reset_out_valid", EW'(out_valid), EW'(1'b0));
        check("reset_c",         EW'(c),         EW'(8'h00));
        check("reset_flags",     EW'(alu_flags), EW'(4'b0000));
        check("reset_in_ready",  EW'(in_ready),  EW'(1'b1));
        check("reset_state",     EW'(dbg_state), EW'(1'b0));

        // ADD overflow then back-to-back SUB with borrow
        issue("add_7f_01", 4'd0, 8'h7F, 8'h01, 8'h80, 4'b1010, 0, 1'b1, 1'b1);
        issue("sub_03_05", 4'd1, 8'h03, 8'h05, 8'hFE, 4'b0110, 0, 1'b1, 1'b1);
        drain();

        // Backpressure: result held, in_ready low, then drain+accept together
        out_ready = 1'b0;
        issue("and_f0_0f", 4'd2, 8'hF0, 8'h0F, 8'h00, 4'b0001, 0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready",  EW'(in_ready),  EW'(1'b0));
            check("bp_out_valid", EW'(out_valid), EW'(1'b1));
            check("bp_hold",      {c, alu_flags}, {8'h00, 4'b0001});
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        issue("or_a0_05",  4'd3, 8'hA0, 8'h05, 8'hA5, 4'b0010, 0, 1'b1, 1'b1);

        // Shifts, logic, bypass and arithmetic edge cases, back to back
        issue("shl_81_1",  4'd6, 8'h81, 8'd1,  8'h02, 4'b0100, 0, 1'b1, 1'b1);
        issue("asr_80_9",  4'd8, 8'h80, 8'd9,  8'hFF, 4'b0110, 0, 1'b1, 1'b1);
        issue("shr_01_0",  4'd7, 8'h01, 8'd0,  8'h01, 4'b0000, 0, 1'b1, 1'b1);
        issue("shl_81_8",  4'd6, 8'h81, 8'd8,  8'h00, 4'b0101, 0, 1'b1, 1'b1);
        issue("shr_81_8",  4'd7, 8'h81, 8'd8,  8'h00, 4'b0101, 0, 1'b1, 1'b1);
        issue("shr_80_9",  4'd7, 8'h80, 8'd9,  8'h00, 4'b0001, 0, 1'b1, 1'b1);
        issue("asr_90_2",  4'd8, 8'h90, 8'd2,  8'hE4, 4'b0010, 0, 1'b1, 1'b1);
        issue("xor_ff_ff", 4'd4, 8'hFF, 8'hFF, 8'h00, 4'b0001, 0, 1'b1, 1'b1);
        issue("not_0f",    4'd5, 8'h0F, 8'h33, 8'hF0, 4'b0010, 0, 1'b1, 1'b1);
        issue("bypa_7f",   4'd9, 8'h7F, 8'h00, 8'h7F, 4'b0000, 0, 1'b1, 1'b1);
        issue("bypb_00",   4'd10, 8'h7F, 8'h00, 8'h00, 4'b0001, 0, 1'b1, 1'b1);
        issue("add_ff_01", 4'd0, 8'hFF, 8'h01, 8'h00, 4'b0101, 0, 1'b1, 1'b1);
        issue("sub_80_01", 4'd1, 8'h80, 8'h01, 8'h7F, 4'b1000, 0, 1'b1, 1'b1);
        issue("illegal_13", 4'd13, 8'h12, 8'h34, 8'h00, 4'b0001, 0, 1'b1, 1'b1);
        drain();

`ifdef ALU_MUL_EN
        // Multiplier: 8 busy cycles with in_ready low, then result
        issue("mul_10_11", 4'd11, 8'h10, 8'h11, 8'h10, 4'b1100, W, 1'b1, 1'b1);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check("mul_busy_in_ready",  EW'(in_ready),  EW'(1'b0));
            check("mul_busy_out_valid", EW'(out_valid), EW'(1'b0));
        end
        issue("mul_0c_0a", 4'd11, 8'h0C, 8'h0A, 8'h78, 4'b0000, W, 1'b1, 1'b1);
        drain();

        // Reset three edges into a MUL
        issue("mul_reset", 4'd11, 8'h0C, 8'h0A, 8'h00, 4'b0000, W, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("mul_state_busy", EW'(dbg_state), EW'(1'b1));
        rst = 1'b1;
`else
        // Op 11 without the multiplier is illegal
        issue("mul_illegal", 4'd11, 8'h10, 8'h11, 8'h00, 4'b0001, 0, 1'b1, 1'b1);
        drain();

        // Reset while a result is held under backpressure
        out_ready = 1'b0;
        issue("held_reset", 4'd0, 8'h11, 8'h22, 8'h33, 4'b0000, 0, 1'b0, 1'b0);
        check("held_out_valid", EW'(out_valid), EW'(1'b1));
        rst = 1'b1;
`endif
        #1;
        check("rst_out_valid", EW'(out_valid), EW'(1'b0));
        check("rst_c",         EW'(c),         EW'(8'h00));
        check("rst_flags",     EW'(alu_flags), EW'(4'b0000));
        check("rst_state",     EW'(dbg_state), EW'(1'b0));
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("post_rst_in_ready", EW'(in_ready), EW'(1'b1));
        issue("add_01_02", 4'd0, 8'h01, 8'h02, 8'h03, 4'b0000, 0, 1'b1, 1'b1);
        drain();

        check_int("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
